// File: rtl/status_snapshot_block.sv
// Status snapshot block: sticky error flags, saturating per-channel error counters and
// live status words captured into a coherent shadow set, served over a registered read port.
module status_snapshot_block #(
    parameter int unsigned N_LIVE = 8,
    parameter int unsigned N_ERR  = 16,
    parameter int unsigned N_CHAN = 5,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_LIVE*32-1:0]  live_status,
    input  logic [N_ERR-1:0]      err_in,
    input  logic [N_CHAN-1:0]     chan_err,
    input  logic                  snap,
    input  logic                  clr_en,
    input  logic [31:0]           clr_mask,
    input  logic                  clr_cnt,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [31:0]           rd_data,
    output logic                  rd_ack,
    output logic                  sticky_any
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N_ERR-1:0]      sticky_q, sticky_d;
    logic [N_CHAN-1:0]     chan_prev_q;
    logic [N_CHAN-1:0]     chan_rise;
    logic [CNT_W-1:0]      cnt_q [N_CHAN];
    logic [CNT_W-1:0]      cnt_d [N_CHAN];

    logic [N_LIVE*32-1:0]  live_sh_q;
    logic [N_ERR-1:0]      sticky_sh_q;
    logic [N_ERR-1:0]      raw_sh_q;
    logic [CNT_W-1:0]      cnt_sh_q [N_CHAN];
    logic [31:0]           snap_count_q;

    logic [31:0]           rd_data_q, rd_mux;
    logic                  rd_ack_q;
    logic                  sticky_any_q;

    // Mask bits above N_ERR have no sticky bit behind them.
    logic unused_clr_mask;
    assign unused_clr_mask = ^clr_mask;

    always_comb begin
        sticky_d  = (sticky_q & ~(clr_mask[N_ERR-1:0] & {N_ERR{clr_en}})) | err_in;
        chan_rise = chan_err & ~chan_prev_q;
        for (int c = 0; c < int'(N_CHAN); c++) begin
            cnt_d[c] = cnt_q[c];
            if (clr_cnt) begin
                cnt_d[c] = chan_rise[c] ? CNT_W'(1) : '0;
            end else if (chan_rise[c] && cnt_q[c] != CNT_MAX) begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
        end
    end

    // Read mux works from shadow registers only, so a read coinciding with snap sees pre-snap data.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < int'(N_LIVE); k++) begin
            if (rd_addr == ADDR_W'(k)) rd_mux = live_sh_q[32*k +: 32];
        end
        if (rd_addr == ADDR_W'(N_LIVE))     rd_mux = 32'(sticky_sh_q);
        if (rd_addr == ADDR_W'(N_LIVE + 1)) rd_mux = 32'(raw_sh_q);
        for (int c = 0; c < int'(N_CHAN); c++) begin
            if (rd_addr == ADDR_W'(N_LIVE + 2 + c)) rd_mux = 32'(cnt_sh_q[c]);
        end
        if (rd_addr == ADDR_W'(N_LIVE + 2 + N_CHAN)) rd_mux = snap_count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_q     <= '0;
            chan_prev_q  <= '0;
            live_sh_q    <= '0;
            sticky_sh_q  <= '0;
            raw_sh_q     <= '0;
            snap_count_q <= '0;
            rd_data_q    <= '0;
            rd_ack_q     <= 1'b0;
            sticky_any_q <= 1'b0;
            for (int c = 0; c < int'(N_CHAN); c++) begin
                cnt_q[c]    <= '0;
                cnt_sh_q[c] <= '0;
            end
        end else begin
            sticky_q     <= sticky_d;
            sticky_any_q <= |sticky_q;
            chan_prev_q  <= chan_err;
            for (int c = 0; c < int'(N_CHAN); c++) begin
                cnt_q[c] <= cnt_d[c];
            end
            if (snap) begin
                live_sh_q    <= live_status;
                sticky_sh_q  <= sticky_d;
                raw_sh_q     <= err_in;
                snap_count_q <= snap_count_q + 32'd1;
                for (int c = 0; c < int'(N_CHAN); c++) begin
                    cnt_sh_q[c] <= cnt_d[c];
                end
            end
            rd_ack_q <= rd_en;
            if (rd_en) rd_data_q <= rd_mux;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_ack     = rd_ack_q;
    assign sticky_any = sticky_any_q;

endmodule

// File: tb/tb_status_snapshot_block.sv
// Directed bench for status_snapshot_block (counter width reduced to 4 to reach saturation quickly).
module tb_status_snapshot_block;

    localparam int N_LIVE = 8;
    localparam int N_ERR  = 16;
    localparam int N_CHAN = 5;
    localparam int CNT_W  = 4;
    localparam int ADDR_W = 6;

    logic                 clk;
    logic                 reset_n;
    logic [N_LIVE*32-1:0] live_status;
    logic [N_ERR-1:0]     err_in;
    logic [N_CHAN-1:0]    chan_err;
    logic                 snap;
    logic                 clr_en;
    logic [31:0]          clr_mask;
    logic                 clr_cnt;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic [31:0]          rd_data;
    logic                 rd_ack;
    logic                 sticky_any;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_snaps = 0;

    status_snapshot_block #(
        .N_LIVE(N_LIVE), .N_ERR(N_ERR), .N_CHAN(N_CHAN), .CNT_W(CNT_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .live_status(live_status), .err_in(err_in),
        .chan_err(chan_err), .snap(snap), .clr_en(clr_en), .clr_mask(clr_mask),
        .clr_cnt(clr_cnt), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_ack(rd_ack), .sticky_any(sticky_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input int addr, input logic [31:0] exp, input string tag);
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(addr);
        step();
        rd_en   = 1'b0;
        chk({tag, "_ack"}, 32'(rd_ack), 32'd1);
        chk(tag, rd_data, exp);
    endtask

    task automatic do_snap();
        snap = 1'b1;
        step();
        snap = 1'b0;
        exp_snaps++;
    endtask

    task automatic pulse_chan(input logic [N_CHAN-1:0] m);
        chan_err = m;
        step();
        chan_err = '0;
        step();
    endtask

    initial begin
        reset_n = 1'b0; err_in = '0; chan_err = '0; snap = 1'b0; clr_en = 1'b0;
        clr_mask = '0; clr_cnt = 1'b0; rd_en = 1'b0; rd_addr = '0;
        for (int k = 0; k < N_LIVE; k++) live_status[32*k +: 32] = 32'hA5A5_0000 + 32'(k);
        repeat (3) step();
        chk("rst_ack", 32'(rd_ack), 32'd0);
        chk("rst_data", rd_data, 32'd0);
        chk("rst_any", 32'(sticky_any), 32'd0);
        reset_n = 1'b1;
        step();

        // Reads return zero before the first snapshot.
        do_read(0, 32'd0, "pre_snap_live0");
        do_read(15, 32'd0, "pre_snap_cnt");

        // Full address map after one snapshot.
        do_snap();
        for (int a = 0; a < 16; a++) begin
            logic [31:0] e;
            e = (a < 8) ? 32'hA5A5_0000 + 32'(a) : (a == 15) ? 32'd1 : 32'd0;
            do_read(a, e, $sformatf("map_%0d", a));
        end
        do_read(16, 32'd0, "map_16");
        do_read(63, 32'd0, "map_63");

        // Sticky set by a one-cycle pulse, raw capture, masked clears.
        err_in = 16'h0008;
        step();
        err_in = '0;
        step();
        chk("any_after_pulse", 32'(sticky_any), 32'd1);
        do_snap();
        do_read(8, 32'h0000_0008, "sticky_pulse");
        do_read(9, 32'h0000_0000, "raw_pulse");
        err_in = 16'h0041;
        do_snap();
        err_in = '0;
        do_read(9, 32'h0000_0041, "raw_held");
        do_read(8, 32'h0000_0049, "sticky_accum");
        clr_en = 1'b1; clr_mask = 32'hFFFF_0008;
        step();
        clr_en = 1'b0;
        do_snap();
        do_read(8, 32'h0000_0041, "sticky_clr_bit3");
        clr_en = 1'b1; clr_mask = 32'h0000_0041;
        step();
        clr_en = 1'b0;
        step();
        step();
        chk("any_after_clr", 32'(sticky_any), 32'd0);
        do_snap();
        do_read(8, 32'd0, "sticky_clr_all");

        // Set and clear in the same cycle: set wins.
        err_in = 16'h0008; clr_en = 1'b1; clr_mask = 32'h0000_0008;
        step();
        step();
        chk("any_set_clr", 32'(sticky_any), 32'd1);
        do_snap();
        err_in = '0;
        step();
        clr_en = 1'b0;
        do_read(8, 32'h0000_0008, "sticky_set_wins");
        step();
        chk("any_released", 32'(sticky_any), 32'd0);

        // Channel counters: 3 edges on ch2, one on ch4.
        pulse_chan(5'b10100);
        pulse_chan(5'b00100);
        chan_err = 5'b00100;
        repeat (10) step();
        do_snap();
        do_read(12, 32'd3, "cnt_ch2_3");
        do_read(14, 32'd1, "cnt_ch4_1");
        do_read(10, 32'd0, "cnt_ch0_0");
        chan_err = '0;
        step();
        for (int i = 0; i < 20; i++) pulse_chan(5'b00100);
        do_snap();
        do_read(12, 32'd15, "cnt_ch2_sat");
        chan_err = 5'b00100; clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0; chan_err = '0;
        step();
        do_snap();
        do_read(12, 32'd1, "cnt_clr_edge");
        do_read(14, 32'd0, "cnt_ch4_clr");
        do_read(15, exp_snaps, "snap_count");

        // Back-to-back reads with a snapshot in the second cycle.
        for (int k = 0; k < N_LIVE; k++) live_status[32*k +: 32] = 32'h5A5A_1000 + 32'(k);
        rd_en = 1'b1; rd_addr = 6'd0;
        step();
        chk("b2b_ack0", 32'(rd_ack), 32'd1);
        chk("b2b_data0", rd_data, 32'hA5A5_0000);
        rd_addr = 6'd1; snap = 1'b1;
        step();
        snap = 1'b0; exp_snaps++;
        chk("b2b_ack1", 32'(rd_ack), 32'd1);
        chk("b2b_data1", rd_data, 32'hA5A5_0001);
        rd_addr = 6'd2;
        step();
        chk("b2b_ack2", 32'(rd_ack), 32'd1);
        chk("b2b_data2", rd_data, 32'h5A5A_1002);
        rd_addr = 6'd3;
        step();
        chk("b2b_ack3", 32'(rd_ack), 32'd1);
        chk("b2b_data3", rd_data, 32'h5A5A_1003);
        rd_en = 1'b0;
        step();
        chk("b2b_ack_off", 32'(rd_ack), 32'd0);
        chk("b2b_data_hold", rd_data, 32'h5A5A_1003);

        // Asynchronous reset in the middle of a read burst.
        rd_en = 1'b1; rd_addr = 6'd15;
        step();
        chk("pre_rst_ack", 32'(rd_ack), 32'd1);
        chk("pre_rst_count", rd_data, exp_snaps);
        rd_addr = 6'd0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_ack", 32'(rd_ack), 32'd0);
        chk("async_rst_data", rd_data, 32'd0);
        step();
        rd_en = 1'b0;
        reset_n = 1'b1;
        exp_snaps = 0;
        step();
        do_read(15, 32'd0, "post_rst_count");
        do_read(0, 32'd0, "post_rst_live0");
        do_read(12, 32'd0, "post_rst_cnt");
        do_snap();
        do_read(15, 32'd1, "post_rst_snap1");
        do_read(0, 32'h5A5A_1000, "post_rst_live_new");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
